// File: rtl/alu_seq_ctrl.sv
// Accumulator sequencer around an external combinational ALU.
// Accepts a command: a load writes the accumulator directly; an ALU op
// presents acc/operand/opcode to the ALU for one cycle, then captures the
// result and flags. Each command ends with a one-cycle done pulse.
module alu_seq_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_opnd,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] ALUctr,
    input  logic [3:0] F,
    input  logic       cf,
    input  logic       zero,
    input  logic       of,
    output logic [3:0] acc,
    output logic [2:0] flags,
    output logic       of_sticky,
    output logic       done,
    output logic [7:0] op_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [2:0] ctr_q, ctr_d;
    logic [3:0] acc_q, acc_d;
    logic [2:0] flags_q, flags_d;
    logic       sticky_q, sticky_d;
    logic [7:0] cnt_q, cnt_d;

    // Ready is held low during reset even though the state already reads idle.
    assign cmd_ready = (state_q == StIdle) & ~clr & rst_n;

    // Next-state logic: clear overrides everything except the ALU operand registers.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        ctr_d    = ctr_q;
        acc_d    = acc_q;
        flags_d  = flags_q;
        sticky_d = sticky_q;
        cnt_d    = cnt_q;
        if (clr) begin
            state_d  = StIdle;
            acc_d    = 4'h0;
            flags_d  = 3'b000;
            sticky_d = 1'b0;
            cnt_d    = 8'h00;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid) begin
                        if (cmd_load) begin
                            acc_d   = cmd_opnd;
                            state_d = StDone;
                        end else begin
                            a_d     = acc_q;
                            b_d     = cmd_opnd;
                            ctr_d   = cmd_op;
                            state_d = StExec;
                        end
                    end
                end
                StExec: begin
                    acc_d    = F;
                    flags_d  = {cf, zero, of};
                    sticky_d = sticky_q | of;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    state_d = StDone;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            ctr_q    <= 3'h0;
            acc_q    <= 4'h0;
            flags_q  <= 3'b000;
            sticky_q <= 1'b0;
            cnt_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctr_q    <= ctr_d;
            acc_q    <= acc_d;
            flags_q  <= flags_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign A         = a_q;
    assign B         = b_q;
    assign ALUctr    = ctr_q;
    assign acc       = acc_q;
    assign flags     = flags_q;
    assign of_sticky = sticky_q;
    assign done      = (state_q == StDone);
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: directed scenarios plus randomized command
// streams checked against a transaction-level model of the accumulator.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_load = 1'b0;
    logic [2:0] cmd_op = 3'h0;
    logic [3:0] cmd_opnd = 4'h0;
    logic [3:0] A, B;
    logic [2:0] ALUctr;
    logic [3:0] F = 4'h0;
    logic       cf = 1'b0, zero = 1'b0, of = 1'b0;
    logic [3:0] acc;
    logic [2:0] flags;
    logic       of_sticky, done;
    logic [7:0] op_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       load;
        logic [2:0] op;
        logic [3:0] opnd;
        logic [3:0] f;
        logic       cf;
        logic       z;
        logic       ov;
    } cmd_t;

    cmd_t cmd_q[$];

    // Reference model: architectural values after each completed command.
    logic [3:0] m_acc = 4'h0, m_a = 4'h0, m_b = 4'h0;
    logic [2:0] m_ctr = 3'h0, m_flags = 3'h0;
    logic       m_sticky = 1'b0;
    logic [7:0] m_cnt = 8'h00;

    alu_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_load  (cmd_load),
        .cmd_op    (cmd_op),
        .cmd_opnd  (cmd_opnd),
        .A         (A),
        .B         (B),
        .ALUctr    (ALUctr),
        .F         (F),
        .cf        (cf),
        .zero      (zero),
        .of        (of),
        .acc       (acc),
        .flags     (flags),
        .of_sticky (of_sticky),
        .done      (done),
        .op_cnt    (op_cnt)
    );

    always #5 clk = ~clk;

    function automatic cmd_t rand_cmd(input int load_pct);
        cmd_t c;
        c.load = ($urandom_range(0, 99) < load_pct);
        c.op   = 3'($urandom);
        c.opnd = 4'($urandom);
        c.f    = 4'($urandom);
        c.cf   = 1'($urandom);
        c.z    = 1'($urandom);
        c.ov   = 1'($urandom);
        return c;
    endfunction

    function automatic cmd_t mk(input logic ld, input logic [2:0] op, input logic [3:0] opnd,
                                input logic [3:0] f, input logic c, input logic z,
                                input logic ov);
        return {ld, op, opnd, f, c, z, ov};
    endfunction

    // Drains cmd_q, one iteration per clock, starting in an idle slot.
    // Ops take 3 cycles from acceptance, loads 2; the ALU result is driven
    // only in the cycle after an op is accepted, random noise otherwise.
    task automatic run_seq(input bit hold, output int iters);
        int   k = 0;
        int   next_free = 0;
        int   exec_it = -1;
        int   done_it = -1;
        int   limit = cmd_q.size() * 4 + 20;
        bit   offered = 1'b0;
        logic exp_rdy;
        cmd_t cur = '0;
        while ((cmd_q.size() > 0 || k <= done_it) && k < limit) begin
            exp_rdy = (k >= next_free);
            checks++;
            if (cmd_ready !== exp_rdy) begin
                errors++;
                $display("FAIL seq_ready: iter %0d cmd_ready=%b expected %b", k, cmd_ready,
                         exp_rdy);
            end
            checks++;
            if (done !== (k == done_it)) begin
                errors++;
                $display("FAIL seq_done: iter %0d done=%b expected %b", k, done, k == done_it);
            end
            if (k == exec_it) begin
                checks++;
                if ({A, B, ALUctr} !== {m_a, m_b, m_ctr}) begin
                    errors++;
                    $display("FAIL exec_operands: A/B/ALUctr=%h/%h/%h expected %h/%h/%h",
                             A, B, ALUctr, m_a, m_b, m_ctr);
                end
                F    = cur.f;
                cf   = cur.cf;
                zero = cur.z;
                of   = cur.ov;
            end else begin
                F    = 4'($urandom);
                cf   = 1'($urandom);
                zero = 1'($urandom);
                of   = 1'($urandom);
            end
            if (k == done_it) begin
                checks++;
                if (acc !== m_acc) begin
                    errors++;
                    $display("FAIL done_acc: acc=%h expected %h", acc, m_acc);
                end
                checks++;
                if ({flags, of_sticky} !== {m_flags, m_sticky}) begin
                    errors++;
                    $display("FAIL done_flags: flags/sticky=%b/%b expected %b/%b", flags,
                             of_sticky, m_flags, m_sticky);
                end
                checks++;
                if (op_cnt !== m_cnt) begin
                    errors++;
                    $display("FAIL done_op_cnt: op_cnt=%0d expected %0d", op_cnt, m_cnt);
                end
                checks++;
                if ({A, B, ALUctr} !== {m_a, m_b, m_ctr}) begin
                    errors++;
                    $display("FAIL hold_operands: A/B/ALUctr=%h/%h/%h expected %h/%h/%h",
                             A, B, ALUctr, m_a, m_b, m_ctr);
                end
            end
            if (!offered && cmd_q.size() > 0) begin
                offered = hold || ($urandom_range(0, 2) != 0);
            end
            if (offered) begin
                cmd_valid = 1'b1;
                cmd_load  = cmd_q[0].load;
                cmd_op    = cmd_q[0].op;
                cmd_opnd  = cmd_q[0].opnd;
            end else begin
                cmd_valid = 1'b0;
                cmd_load  = 1'($urandom);
                cmd_op    = 3'($urandom);
                cmd_opnd  = 4'($urandom);
            end
            if (offered && k >= next_free) begin
                cur     = cmd_q.pop_front();
                offered = 1'b0;
                if (cur.load) begin
                    m_acc     = cur.opnd;
                    exec_it   = -1;
                    done_it   = k + 1;
                    next_free = k + 2;
                end else begin
                    m_a      = m_acc;
                    m_b      = cur.opnd;
                    m_ctr    = cur.op;
                    m_acc    = cur.f;
                    m_flags  = {cur.cf, cur.z, cur.ov};
                    m_sticky = m_sticky | cur.ov;
                    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
                    exec_it   = k + 1;
                    done_it   = k + 2;
                    next_free = k + 3;
                end
            end
            @(posedge clk);
            #1;
            k++;
        end
        cmd_valid = 1'b0;
        checks++;
        if (k >= limit) begin
            errors++;
            $display("FAIL seq_timeout: stopped at iter %0d, limit %0d", k, limit);
        end
        iters = k;
    endtask

    task automatic model_zero();
        m_acc = 4'h0; m_a = 4'h0; m_b = 4'h0; m_ctr = 3'h0;
        m_flags = 3'h0; m_sticky = 1'b0; m_cnt = 8'h00;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({A, B, ALUctr, acc, flags, of_sticky, done, op_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {A, B, ALUctr, acc, flags, of_sticky, done, op_cnt});
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready_low: cmd_ready=%b expected 0", cmd_ready);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready_after: cmd_ready=%b expected 1", cmd_ready);
        end
        model_zero();
    endtask

    task automatic test_load_op();
        int it;
        cmd_q.push_back(mk(1'b1, 3'd0, 4'b0101, 4'h0, 1'b0, 1'b0, 1'b0));
        cmd_q.push_back(mk(1'b0, 3'd3, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0));
        run_seq(1'b1, it);
        checks++;
        if ({acc, flags, op_cnt} !== {4'b1111, 3'b000, 8'd1}) begin
            errors++;
            $display("FAIL load_op_result: acc/flags/op_cnt=%b/%b/%0d expected 1111/000/1",
                     acc, flags, op_cnt);
        end
        checks++;
        if ({A, B, ALUctr} !== {4'b0101, 4'b1010, 3'd3}) begin
            errors++;
            $display("FAIL load_op_operands: A/B/ALUctr=%b/%b/%0d expected 0101/1010/3",
                     A, B, ALUctr);
        end
    endtask

    task automatic test_overflow();
        int it;
        cmd_q.push_back(mk(1'b1, 3'd0, 4'b0111, 4'h0, 1'b0, 1'b0, 1'b0));
        cmd_q.push_back(mk(1'b0, 3'd0, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1));
        run_seq(1'b1, it);
        checks++;
        if ({flags, of_sticky} !== 4'b0011) begin
            errors++;
            $display("FAIL overflow_set: flags/sticky=%b/%b expected 001/1", flags, of_sticky);
        end
        cmd_q.push_back(mk(1'b0, 3'd1, 4'b0110, 4'b0010, 1'b0, 1'b0, 1'b0));
        run_seq(1'b1, it);
        checks++;
        if ({flags, of_sticky} !== 4'b0001) begin
            errors++;
            $display("FAIL overflow_sticky: flags/sticky=%b/%b expected 000/1", flags,
                     of_sticky);
        end
        checks++;
        if (op_cnt !== 8'd3) begin
            errors++;
            $display("FAIL overflow_op_cnt: op_cnt=%0d expected 3", op_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int it;
        int total = 0;
        cmd_t c;
        for (int i = 0; i < 16; i++) begin
            c = rand_cmd(35);
            total += c.load ? 2 : 3;
            cmd_q.push_back(c);
        end
        run_seq(1'b1, it);
        checks++;
        if (it !== total) begin
            errors++;
            $display("FAIL back_to_back_cycles: took %0d cycles expected %0d", it, total);
        end
    endtask

    task automatic test_random();
        int it;
        for (int i = 0; i < 60; i++) cmd_q.push_back(rand_cmd(30));
        run_seq(1'b0, it);
    endtask

    task automatic test_saturation();
        int it;
        for (int i = 0; i < 260; i++) cmd_q.push_back(rand_cmd(0));
        run_seq(1'b1, it);
        checks++;
        if (op_cnt !== 8'hFF) begin
            errors++;
            $display("FAIL saturation: op_cnt=%h expected ff", op_cnt);
        end
    endtask

    task automatic test_clr();
        int it;
        cmd_q.push_back(mk(1'b1, 3'd0, 4'hC, 4'h0, 1'b0, 1'b0, 1'b0));
        cmd_q.push_back(mk(1'b0, 3'd4, 4'h7, 4'hB, 1'b1, 1'b0, 1'b1));
        run_seq(1'b1, it);
        // Op accepted, then clr asserted during its execute cycle.
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd5; cmd_opnd = 4'h3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        F = 4'hA; cf = 1'b1; zero = 1'b0; of = 1'b1;
        clr = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, acc, flags, of_sticky, op_cnt} !== 17'h0) begin
            errors++;
            $display("FAIL clr_exec: done/acc/flags/sticky/op_cnt=%b/%h/%b/%b/%0d expected 0",
                     done, acc, flags, of_sticky, op_cnt);
        end
        checks++;
        if ({A, B, ALUctr} !== {4'hB, 4'h3, 3'd5}) begin
            errors++;
            $display("FAIL clr_keeps_operands: A/B/ALUctr=%h/%h/%h expected b/3/5", A, B,
                     ALUctr);
        end
        clr = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_idle: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_done: done=%b expected 0", done);
        end
        // clr together with a valid load in idle: the load must be refused.
        clr = 1'b1; cmd_valid = 1'b1; cmd_load = 1'b1; cmd_opnd = 4'h9;
        #1;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_ready_low: cmd_ready=%b expected 0", cmd_ready);
        end
        @(posedge clk);
        #1;
        clr = 1'b0; cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({done, acc} !== 5'h0) begin
            errors++;
            $display("FAIL clr_wins: done/acc=%b/%h expected 0/0", done, acc);
        end
        model_zero();
        m_a = 4'hB; m_b = 4'h3; m_ctr = 3'd5;
    endtask

    task automatic test_async_reset();
        int it;
        cmd_q.push_back(mk(1'b1, 3'd0, 4'h6, 4'h0, 1'b0, 1'b0, 1'b0));
        run_seq(1'b1, it);
        cmd_valid = 1'b1; cmd_load = 1'b0; cmd_op = 3'd2; cmd_opnd = 4'h9;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        F = 4'hF; cf = 1'b1; zero = 1'b0; of = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({A, B, ALUctr, acc, flags, of_sticky, done, op_cnt} !== 28'h0) begin
            errors++;
            $display("FAIL async_reset_outputs: got %h expected 0",
                     {A, B, ALUctr, acc, flags, of_sticky, done, op_cnt});
        end
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_ready: cmd_ready=%b expected 0", cmd_ready);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, done, acc, op_cnt} !== {1'b1, 1'b0, 4'h0, 8'h00}) begin
            errors++;
            $display("FAIL async_reset_release: ready/done/acc/op_cnt=%b/%b/%h/%0d expected 1/0/0/0",
                     cmd_ready, done, acc, op_cnt);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({done, acc, flags} !== 8'h0) begin
            errors++;
            $display("FAIL async_reset_abort: done/acc/flags=%b/%h/%b expected 0/0/000", done,
                     acc, flags);
        end
        model_zero();
    endtask

    initial begin
        test_reset();
        test_load_op();
        test_overflow();
        test_back_to_back();
        test_random();
        test_saturation();
        test_clr();
        test_random();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
